// File: rtl/llc_ctrl.sv
// llc_ctrl: sequencing controller for the set-associative last-level cache.
// It accepts one trace command at a time, reads the indexed set and compares
// tags. It then applies MESI and LRU-rank updates, issues bus operations,
// answers snoops, writes the set back and keeps hit/miss statistics. It is
// the only writer of the cache array.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid, cmd    trace command (opcode n, 32-bit address); cmd_ready in IDLE
//   arr_rd_en         array read strobe; arr_rd_data valid the next cycle
//   arr_wr_en         write all ways of set arr_set with arr_wr_data
//   arr_set           set addressed by the current read or write
//   snoop_result      other caches' reply to our bus READ
//   bus_op_valid      one-cycle pulse qualifying bus_op / bus_addr
//   snoop_resp        our reply to the last snoop command, held until next command
//   done              one-cycle pulse when a command retires
//   *_count           saturating statistics for opcodes 0/1/2
//
// State   | meaning
// IDLE    | waiting for a command; array read launched on accept
// RD      | array read data arriving, captured into the set register
// EVAL    | tag compare, MESI/LRU update, statistics, choose next step
// EVICT   | bus WRITE of the dirty victim line
// BUS     | READ / INVALIDATE / RWIM / WRITE for the command's own line
// WR      | write the updated set back to the array
// CLEAR   | walk every set writing the reset pattern
// DONE    | retire pulse

package llc_pkg;
    localparam int WAYS   = 8;
    localparam int TAG_W  = 12;
    localparam int IDX_W  = 14;
    localparam int LRU_W  = 3;
    localparam int DATA_W = 32;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [2:0] BUS_NONE  = 3'd0;
    localparam logic [2:0] BUS_READ  = 3'd1;
    localparam logic [2:0] BUS_WRITE = 3'd2;
    localparam logic [2:0] BUS_INVAL = 3'd3;
    localparam logic [2:0] BUS_RWIM  = 3'd4;

    localparam logic [1:0] SNP_NOHIT = 2'd0;
    localparam logic [1:0] SNP_HIT   = 2'd1;
    localparam logic [1:0] SNP_HITM  = 2'd2;

    typedef struct packed {
        logic [3:0]  n;
        logic [31:0] addr;
    } command_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [1:0]        mesi;
        logic [LRU_W-1:0]  lru;
        logic [DATA_W-1:0] data;
    } cache_line_t;
endpackage

module llc_ctrl
    import llc_pkg::*;
#(
    parameter int SETS = 16384
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    input  command_t                     cmd,
    output logic                         cmd_ready,
    output logic                         arr_rd_en,
    output logic                         arr_wr_en,
    output logic [IDX_W-1:0]             arr_set,
    input  cache_line_t [WAYS-1:0]       arr_rd_data,
    output cache_line_t [WAYS-1:0]       arr_wr_data,
    input  logic [1:0]                   snoop_result,
    output logic                         bus_op_valid,
    output logic [2:0]                   bus_op,
    output logic [31:0]                  bus_addr,
    output logic [1:0]                   snoop_resp,
    output logic                         done,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count,
    output logic [31:0]                  read_count,
    output logic [31:0]                  write_count
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD, ST_EVAL, ST_EVICT, ST_BUS, ST_WR, ST_CLEAR, ST_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
    localparam logic [LRU_W-1:0] LRU_MAX  = LRU_W'(WAYS - 1);

    state_t                   state_q, state_d;
    logic [3:0]               n_q;
    logic [TAG_W-1:0]         tag_q;
    logic [IDX_W-1:0]         idx_q;
    cache_line_t [WAYS-1:0]   set_q;
    logic [LRU_W-1:0]         way_q;
    logic [TAG_W-1:0]         evict_tag_q;
    logic [2:0]               bus_op_q;
    logic                     fill_q;
    logic [IDX_W-1:0]         clr_q;
    logic [1:0]               snoop_resp_q;
    logic [31:0]              hit_q, miss_q, rd_cnt_q, wr_cnt_q;

    // Byte offset never affects line-granular behaviour.
    logic unused_offset;
    assign unused_offset = ^cmd.addr[5:0];

    // EVAL decode results
    logic                     hit, has_inv;
    logic [LRU_W-1:0]         hit_way, inv_way, lru_way, victim_way, acc_way, old_rank;
    cache_line_t [WAYS-1:0]   lru_set, eval_set;
    logic [2:0]               eval_op;
    logic                     eval_evict, eval_wr, eval_fill;
    logic [1:0]               eval_resp;
    logic                     is_access, is_snoop;

    assign is_access = (n_q < 4'd3);
    assign is_snoop  = (n_q >= 4'd3) && (n_q <= 4'd6);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        has_inv    = 1'b0;
        inv_way    = '0;
        lru_way    = '0;
        // Descending scans so the lowest matching index wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (set_q[i].tag == tag_q && set_q[i].mesi != MESI_I) begin
                hit     = 1'b1;
                hit_way = LRU_W'(i);
            end
            if (set_q[i].mesi == MESI_I) begin
                has_inv = 1'b1;
                inv_way = LRU_W'(i);
            end
            if (set_q[i].lru == LRU_MAX) begin
                lru_way = LRU_W'(i);
            end
        end
        victim_way = has_inv ? inv_way : lru_way;
        acc_way    = hit ? hit_way : victim_way;
        old_rank   = set_q[acc_way].lru;

        // Move-to-front: ranks below the accessed way's old rank age by one.
        for (int i = 0; i < WAYS; i++) begin
            lru_set[i] = set_q[i];
            if (LRU_W'(i) == acc_way) begin
                lru_set[i].lru = '0;
            end else if (set_q[i].lru < old_rank) begin
                lru_set[i].lru = set_q[i].lru + 1'b1;
            end
        end

        eval_set   = set_q;
        eval_op    = BUS_NONE;
        eval_evict = 1'b0;
        eval_wr    = 1'b1;
        eval_fill  = 1'b0;
        eval_resp  = SNP_NOHIT;
        case (n_q)
            4'd0, 4'd2: begin
                eval_set = lru_set;
                if (!hit) begin
                    eval_set[victim_way].tag  = tag_q;
                    eval_set[victim_way].mesi = MESI_E;
                    eval_op    = BUS_READ;
                    eval_fill  = 1'b1;
                    eval_evict = (set_q[victim_way].mesi == MESI_M);
                end
            end
            4'd1: begin
                eval_set = lru_set;
                eval_set[acc_way].mesi = MESI_M;
                if (hit) begin
                    if (set_q[hit_way].mesi == MESI_S) eval_op = BUS_INVAL;
                end else begin
                    eval_set[victim_way].tag = tag_q;
                    eval_op    = BUS_RWIM;
                    eval_evict = (set_q[victim_way].mesi == MESI_M);
                end
            end
            4'd3: begin
                eval_wr = hit;
                if (hit && set_q[hit_way].mesi == MESI_S) eval_set[hit_way].mesi = MESI_I;
            end
            4'd4, 4'd6: begin
                eval_wr = hit;
                if (hit) begin
                    eval_set[hit_way].mesi = (n_q == 4'd4) ? MESI_S : MESI_I;
                    if (set_q[hit_way].mesi == MESI_M) begin
                        eval_resp = SNP_HITM;
                        eval_op   = BUS_WRITE;
                    end else begin
                        eval_resp = SNP_HIT;
                    end
                end
            end
            default: eval_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd.n <= 4'd6)      state_d = ST_RD;
                    else if (cmd.n == 4'd8) state_d = ST_CLEAR;
                    else                    state_d = ST_DONE;
                end
            end
            ST_RD:    state_d = ST_EVAL;
            ST_EVAL: begin
                if (eval_evict)              state_d = ST_EVICT;
                else if (eval_op != BUS_NONE) state_d = ST_BUS;
                else if (eval_wr)            state_d = ST_WR;
                else                         state_d = ST_DONE;
            end
            ST_EVICT: state_d = ST_BUS;
            ST_BUS:   state_d = ST_WR;
            ST_WR:    state_d = ST_DONE;
            ST_CLEAR: if (clr_q == LAST_SET) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == ST_IDLE);
        arr_rd_en    = (state_q == ST_IDLE) && cmd_valid && (cmd.n <= 4'd6);
        arr_wr_en    = (state_q == ST_WR) || (state_q == ST_CLEAR);
        arr_set      = '0;
        arr_wr_data  = '0;
        bus_op_valid = (state_q == ST_EVICT) || (state_q == ST_BUS);
        bus_op       = BUS_NONE;
        bus_addr     = '0;
        done         = (state_q == ST_DONE);
        if (arr_rd_en) arr_set = cmd.addr[19:6];
        case (state_q)
            ST_WR: begin
                arr_set     = idx_q;
                arr_wr_data = set_q;
            end
            ST_CLEAR: begin
                arr_set = clr_q;
                for (int j = 0; j < WAYS; j++) begin
                    arr_wr_data[j].tag  = '0;
                    arr_wr_data[j].mesi = MESI_I;
                    arr_wr_data[j].lru  = LRU_W'(j);
                    arr_wr_data[j].data = DATA_W'(clr_q);
                end
            end
            ST_EVICT: begin
                bus_op   = BUS_WRITE;
                bus_addr = {evict_tag_q, idx_q, 6'b0};
            end
            ST_BUS: begin
                bus_op   = bus_op_q;
                bus_addr = {tag_q, idx_q, 6'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            set_q        <= '0;
            way_q        <= '0;
            evict_tag_q  <= '0;
            bus_op_q     <= BUS_NONE;
            fill_q       <= 1'b0;
            clr_q        <= '0;
            snoop_resp_q <= SNP_NOHIT;
            hit_q        <= '0;
            miss_q       <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        n_q          <= cmd.n;
                        tag_q        <= cmd.addr[31:20];
                        idx_q        <= cmd.addr[19:6];
                        snoop_resp_q <= SNP_NOHIT;
                        if (cmd.n == 4'd8) begin
                            clr_q    <= '0;
                            hit_q    <= '0;
                            miss_q   <= '0;
                            rd_cnt_q <= '0;
                            wr_cnt_q <= '0;
                        end
                    end
                end
                ST_RD: set_q <= arr_rd_data;
                ST_EVAL: begin
                    set_q       <= eval_set;
                    way_q       <= acc_way;
                    evict_tag_q <= set_q[victim_way].tag;
                    bus_op_q    <= eval_op;
                    fill_q      <= eval_fill;
                    if (is_snoop) snoop_resp_q <= eval_resp;
                    if (is_access) begin
                        if (hit) hit_q  <= sat_inc(hit_q);
                        else     miss_q <= sat_inc(miss_q);
                        if (n_q == 4'd1) wr_cnt_q <= sat_inc(wr_cnt_q);
                        else             rd_cnt_q <= sat_inc(rd_cnt_q);
                    end
                end
                // A read fill is shared if any other cache reported the line.
                ST_BUS: begin
                    if (fill_q && (snoop_result == SNP_HIT || snoop_result == SNP_HITM))
                        set_q[way_q].mesi <= MESI_S;
                end
                ST_CLEAR: clr_q <= clr_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign snoop_resp  = snoop_resp_q;
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;
    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;

endmodule
